inst_rom_stage: RTL and testbench
=================================

INST_ROM_STAGE -- requirements
Module: inst_rom_stage

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- AW, 11, program-counter/address width
- IW, 9, instruction width
- LUT_AW, 4, branch-target LUT index width
REQ-002 SHALL have ports (name, direction, width, meaning):
- Clk, in, 1, single clock; all state updates on posedge
- Reset, in, 1, synchronous, active-high reset
- Start, in, 1, program start/hold request (same signal driving the fetch unit)
- ProgCtr, in, AW, current PC from the fetch unit
- BranchTaken, in, 1, taken-branch resolution from the execute stage (BRANCH & ALU_ZERO)
- Instruction, out, IW, registered instruction word
- InstValid, out, 1, Instruction is live this cycle
- BRANCH, out, 1, valid instruction is a branch
- Target, out, AW, branch target address for the fetch unit
- Done, out, 1, program has reached HALT

Function
REQ-003 SHALL hold a 2^AW x IW instruction ROM and a 2^LUT_AW x AW target LUT, both initialised at elaboration and read-only.
REQ-004 SHALL read the ROM synchronously: Instruction in cycle N+1 = ROM[ProgCtr sampled in cycle N], for one cycle of latency.
REQ-005 SHALL implement FSM states IDLE, PRIME, RUN, HALT.
REQ-006 IDLE: InstValid=0, Done=0; stay while Start=1 or Start never asserted; leave on the first cycle with Start=0 after a cycle with Start=1, going to PRIME.
REQ-007 PRIME: single cycle, InstValid=0 (absorbs ROM latency); unconditional transition to RUN.
REQ-008 RUN: InstValid=1, except as in REQ-011; Instruction carries the registered ROM word.
REQ-009 Decode: opcode = Instruction[8:5]; BRANCH=1 iff InstValid=1 and opcode=4'b1100; Target = LUT[Instruction[LUT_AW-1:0]] when BRANCH=1, else 0.
REQ-010 HALT encoding SHALL be Instruction = 9'h1FF; a valid HALT in RUN SHALL move to HALT next cycle; the HALT word itself is presented with InstValid=1, BRANCH=0.
REQ-011 BranchTaken=1 in RUN SHALL squash the next cycle (InstValid=0, BRANCH=0), which is the wrong-path word fetched before the fetch unit redirected; the cycle after that SHALL be valid and hold ROM[Target].
REQ-012 BranchTaken SHALL be ignored in IDLE, PRIME, HALT and on squashed cycles.
REQ-013 HALT: Done=1, InstValid=0, BRANCH=0; hold until Start=1, then go to IDLE (Done drops the cycle after Start is seen).
REQ-014 Start=1 in RUN or PRIME SHALL abort to IDLE next cycle, with InstValid=0 from that cycle onward.
REQ-015 Simultaneous valid HALT word and BranchTaken=1: HALT wins; go to HALT.
REQ-016 ProgCtr SHALL wrap naturally; address 2^AW-1 followed by 0 needs no special handling.

Reset
REQ-017 Reset=1 at a posedge SHALL force state IDLE, Instruction=0, InstValid=0, BRANCH=0, Target=0, Done=0, and clear the squash flag; this holds in every state, including mid-RUN.
REQ-018 Reset SHALL have priority over Start and BranchTaken in the same cycle.
REQ-019 ROM and LUT contents SHALL NOT be altered by Reset.

Verification
REQ-020 Bench SHALL cover these scenarios:
- Reset 2 cycles, Start pulse 1 cycle, ProgCtr incrementing from 0 -> PRIME for 1 cycle, then InstValid=1 with Instruction = ROM[0], ROM[1], ... one cycle behind ProgCtr.
- ROM[3] = 9'b1100_00010, LUT[2] = 11'd40, BranchTaken=1 while ROM[3] is valid -> BRANCH=1 and Target=40 in that cycle, next cycle InstValid=0, following cycle Instruction = ROM[40].
- ROM[5] = 9'h1FF -> Instruction=1FF with InstValid=1, then Done=1 and InstValid=0 held for 10+ cycles; Start=1 -> IDLE with Done=0.
- Reset=1 asserted mid-RUN at PC=7 -> next cycle all outputs 0, state IDLE; no InstValid until a new Start sequence.
- Start=1 asserted mid-RUN -> InstValid=0 next cycle; Start released -> PRIME, then RUN from ROM[0].
- HALT word valid together with BranchTaken=1 -> Done=1 next cycle, no squash cycle and no redirect.

Source files
------------

// File: rtl/inst_rom_stage.sv
// -----------------------------------------------------------------------------
// inst_rom_stage
//
// Purpose:
//   Instruction-memory stage of the pipeline. The stage holds a read-only
//   program ROM and a branch-target lookup table. It reads the ROM one cycle
//   behind the fetch unit's program counter. A small control FSM decides when
//   the registered word is a live instruction. The FSM sequences program
//   start-up, normal running, taken-branch squashing, and the HALT condition.
//
// Parameters:
//   AW      - program-counter / ROM address width
//   IW      - instruction width (decode fields assume IW = 9)
//   LUT_AW  - branch-target LUT index width
//
// Ports:
//   Clk          in   clock, all state updates on the rising edge
//   Reset        in   synchronous active-high reset
//   Start        in   program start/hold request (shared with the fetch unit)
//   ProgCtr      in   current PC from the fetch unit
//   BranchTaken  in   taken-branch resolution from the execute stage
//   Instruction  out  registered ROM word
//   InstValid    out  Instruction is a live instruction this cycle
//   BRANCH       out  live instruction is a branch
//   Target       out  branch target from the LUT (0 when not a branch)
//   Done         out  program has executed HALT
// -----------------------------------------------------------------------------
module inst_rom_stage #(
  parameter int AW     = 11,
  parameter int IW     = 9,
  parameter int LUT_AW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] ProgCtr,
  input  logic          BranchTaken,
  output logic [IW-1:0] Instruction,
  output logic          InstValid,
  output logic          BRANCH,
  output logic [AW-1:0] Target,
  output logic          Done
);

  localparam logic [3:0]    OP_BRANCH = 4'b1100;
  localparam logic [IW-1:0] HALT_WORD = '1;

  // Program image. Filler words keep the top bit clear, so they can never
  // decode as a branch or as HALT. A handful of fixed words place branches
  // and HALTs at known addresses.
  function automatic logic [IW-1:0] rom_word(input int addr);
    logic [IW-1:0] w;
    case (addr)
      3:       w = IW'(9'b1100_00010);
      5:       w = IW'(9'h1FF);
      20:      w = IW'(9'b1100_00111);
      45:      w = IW'(9'b1100_01001);
      77:      w = IW'(9'b1100_11110);
      130:     w = IW'(9'h1FF);
      default: w = IW'((addr ^ (addr >> 3)) & 255);
    endcase
    return w;
  endfunction

  // Branch-target table: entry i jumps to address 20*i.
  function automatic logic [AW-1:0] lut_word(input int idx);
    return AW'(idx * 20);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    HALT
  } state_t;

  logic [IW-1:0] rom [2**AW];
  logic [AW-1:0] lut [2**LUT_AW];

  state_t        state;
  state_t        state_next;
  logic          squash;
  logic          squash_next;
  logic          start_q;
  logic [IW-1:0] instr_q;

  // Both tables are constant nets fixed at elaboration. Reset never
  // touches them.
  for (genvar g = 0; g < 2**AW; g++) begin : g_rom
    assign rom[g] = rom_word(g);
  end

  for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_lut
    assign lut[g] = lut_word(g);
  end

  // The ROM word is registered every cycle, whatever the FSM state. The FSM
  // only qualifies the word. start_q remembers last cycle's Start, so IDLE
  // can detect the release of a Start pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      squash  <= 1'b0;
      start_q <= 1'b0;
      instr_q <= '0;
    end else begin
      state   <= state_next;
      squash  <= squash_next;
      start_q <= Start;
      instr_q <= rom[ProgCtr];
    end
  end

  // Next-state logic and qualification of the registered word.
  // In RUN the priority order is: abort on Start, then HALT, then
  // squash on a taken branch. A squashed word ignores BranchTaken and HALT,
  // because it was fetched from the wrong path.
  always_comb begin
    state_next  = state;
    squash_next = 1'b0;
    InstValid   = 1'b0;
    Done        = 1'b0;
    case (state)
      IDLE: begin
        if (start_q && !Start) state_next = PRIME;
      end
      PRIME: begin
        state_next = Start ? IDLE : RUN;
      end
      RUN: begin
        InstValid = !squash;
        if (Start)                                 state_next  = IDLE;
        else if (!squash && instr_q == HALT_WORD)  state_next  = HALT;
        else if (!squash && BranchTaken)           squash_next = 1'b1;
      end
      HALT: begin
        Done = 1'b1;
        if (Start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Instruction = instr_q;
  assign BRANCH      = InstValid && (instr_q[8:5] == OP_BRANCH);
  assign Target      = BRANCH ? lut[instr_q[LUT_AW-1:0]] : '0;

endmodule

// File: tb/tb_inst_rom_stage.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_stage
//
// Purpose:
//   Self-checking bench for inst_rom_stage. A driver plays the role of the
//   fetch unit and steps a reference model of the stage each cycle. The model
//   pushes the expected outputs for that cycle into a queue. A monitor pops
//   one entry per cycle on the falling edge and compares it with the DUT.
//
// Ports: none (top-level bench)
// -----------------------------------------------------------------------------
module tb_inst_rom_stage;

  localparam int AW     = 11;
  localparam int IW     = 9;
  localparam int LUT_AW = 4;

  logic          Clk         = 1'b0;
  logic          Reset       = 1'b1;
  logic          Start       = 1'b0;
  logic          BranchTaken = 1'b0;
  logic [AW-1:0] ProgCtr     = '0;
  logic [IW-1:0] Instruction;
  logic          InstValid;
  logic          BRANCH;
  logic [AW-1:0] Target;
  logic          Done;

  inst_rom_stage #(.AW(AW), .IW(IW), .LUT_AW(LUT_AW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .ProgCtr     (ProgCtr),
    .BranchTaken (BranchTaken),
    .Instruction (Instruction),
    .InstValid   (InstValid),
    .BRANCH      (BRANCH),
    .Target      (Target),
    .Done        (Done)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic          valid;
    logic          done;
    logic          check_instr;
    logic [IW-1:0] instr;
    logic          branch;
    logic [AW-1:0] target;
  } expect_t;

  typedef enum {M_IDLE, M_PRIME, M_RUN, M_HALT} phase_t;

  expect_t exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  // The bench keeps its own copy of the program image and the target table.
  logic [IW-1:0] ref_rom [2**AW];
  logic [AW-1:0] ref_lut [2**LUT_AW];

  // Reference model state: the program phase, a pending wrong-path bubble,
  // the word the ROM is presenting, and whether a reset has just happened.
  phase_t        m_phase      = M_IDLE;
  logic          m_bubble     = 1'b0;
  logic          m_start_prev = 1'b0;
  logic [IW-1:0] m_word       = '0;
  logic          m_reset_seen = 1'b0;

  logic [AW-1:0] prev_target = '0;
  logic [AW-1:0] prime_pc    = '0;
  logic          rand_jumps  = 1'b0;

  function automatic expect_t predict();
    expect_t e;
    e.valid       = (m_phase == M_RUN) && !m_bubble;
    e.done        = (m_phase == M_HALT);
    e.instr       = m_word;
    e.check_instr = e.valid || m_reset_seen;
    e.branch      = e.valid && (m_word[8:5] == 4'b1100);
    e.target      = e.branch ? ref_lut[m_word[3:0]] : '0;
    return e;
  endfunction

  // Advance the model across one clock edge, using the inputs that were
  // applied during the cycle that is ending.
  task automatic model_step(input logic r, input logic s, input logic bt,
                            input logic [AW-1:0] pc);
    expect_t now;
    logic    bubble_next;
    now = predict();
    if (r) begin
      m_phase      = M_IDLE;
      m_bubble     = 1'b0;
      m_start_prev = 1'b0;
      m_word       = '0;
      m_reset_seen = 1'b1;
      return;
    end
    m_reset_seen = 1'b0;
    bubble_next  = 1'b0;
    case (m_phase)
      M_IDLE:  if (m_start_prev && !s) m_phase = M_PRIME;
      M_PRIME: m_phase = s ? M_IDLE : M_RUN;
      M_RUN: begin
        if (s)                                 m_phase     = M_IDLE;
        else if (now.valid && m_word == 9'h1FF) m_phase     = M_HALT;
        else if (now.valid && bt)              bubble_next = 1'b1;
      end
      M_HALT:  if (s) m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
    m_bubble     = bubble_next;
    m_start_prev = s;
    m_word       = ref_rom[pc];
  endtask

  // One clock cycle of stimulus. bt_mode: 0 never, 1 take every branch,
  // 2 assert on a HALT word, 3 always assert, 4 take branches at random.
  task automatic apply_stimulus(input logic r, input logic s, input int bt_mode);
    expect_t       e;
    logic          bt;
    logic [AW-1:0] pc;
    @(posedge Clk);
    #1;
    model_step(Reset, Start, BranchTaken, ProgCtr);
    e = predict();
    exp_q.push_back(e);
    case (m_phase)
      M_RUN: begin
        if (m_bubble)                                   pc = prev_target;
        else if (rand_jumps && $urandom_range(15) == 0) pc = AW'($urandom);
        else                                            pc = ProgCtr + AW'(1);
      end
      M_PRIME: pc = prime_pc;
      default: pc = '0;
    endcase
    case (bt_mode)
      1:       bt = e.branch;
      2:       bt = e.valid && (e.instr == 9'h1FF);
      3:       bt = 1'b1;
      4:       bt = e.branch && ($urandom_range(1) == 1);
      default: bt = 1'b0;
    endcase
    Reset       = r;
    Start       = s;
    BranchTaken = bt;
    ProgCtr     = pc;
    prev_target = e.target;
  endtask

  // Scoreboard monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge Clk) begin : monitor
    expect_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (InstValid !== e.valid) begin
        n_miss++;
        $display("[TB] FAIL InstValid @%0t: got %b expected %b", $time, InstValid, e.valid);
      end
      if (Done !== e.done) begin
        n_miss++;
        $display("[TB] FAIL Done @%0t: got %b expected %b", $time, Done, e.done);
      end
      if (BRANCH !== e.branch) begin
        n_miss++;
        $display("[TB] FAIL BRANCH @%0t: got %b expected %b", $time, BRANCH, e.branch);
      end
      if (Target !== e.target) begin
        n_miss++;
        $display("[TB] FAIL Target @%0t: got %0d expected %0d", $time, Target, e.target);
      end
      if (e.check_instr && Instruction !== e.instr) begin
        n_miss++;
        $display("[TB] FAIL Instruction @%0t: got %h expected %h", $time, Instruction, e.instr);
      end
    end
  end

  initial begin : stimulus
    logic r;
    logic s;
    int   m;

    for (int a = 0; a < 2**AW; a++) ref_rom[a] = IW'((a % 256) ^ ((a / 8) % 256));
    ref_rom[3]   = 9'b1100_00010;
    ref_rom[5]   = 9'h1FF;
    ref_rom[20]  = 9'b1100_00111;
    ref_rom[45]  = 9'b1100_01001;
    ref_rom[77]  = 9'b1100_11110;
    ref_rom[130] = 9'h1FF;
    for (int i = 0; i < 2**LUT_AW; i++) ref_lut[i] = AW'(i * 20);

    // Reset for two cycles, idle with no Start, then a one-cycle Start pulse.
    // The program runs from address 0, passes the untaken branch at 3,
    // reaches HALT at 5, and then sits in HALT.
    $display("[TB] sequential run to HALT");
    apply_stimulus(1'b1, 1'b0, 0);
    apply_stimulus(1'b1, 1'b0, 0);
    repeat (3) apply_stimulus(1'b0, 1'b0, 0);
    apply_stimulus(1'b0, 1'b1, 0);
    repeat (20) apply_stimulus(1'b0, 1'b0, 0);

    // Leave HALT with Start. Releasing Start restarts the program.
    // The branch at 3 is taken this time (target 40).
    $display("[TB] restart and taken branch");
    apply_stimulus(1'b0, 1'b1, 0);
    repeat (10) apply_stimulus(1'b0, 1'b0, 1);

    // Abort mid-run with Start held for two cycles, then release it.
    // The program then runs from 0 again. BranchTaken is asserted together
    // with the HALT word.
    $display("[TB] abort, restart, HALT with BranchTaken");
    apply_stimulus(1'b0, 1'b1, 0);
    apply_stimulus(1'b0, 1'b1, 0);
    repeat (12) apply_stimulus(1'b0, 1'b0, 2);

    // Reset in HALT, applied together with Start and BranchTaken.
    // No restart may follow.
    apply_stimulus(1'b1, 1'b1, 3);
    repeat (4) apply_stimulus(1'b0, 1'b0, 0);

    // Start at address 6 and assert Reset while the fetch PC is 7.
    $display("[TB] reset mid-run");
    prime_pc = AW'(6);
    apply_stimulus(1'b0, 1'b1, 0);
    apply_stimulus(1'b0, 1'b0, 0);
    apply_stimulus(1'b0, 1'b0, 0);
    apply_stimulus(1'b1, 1'b0, 0);
    repeat (6) apply_stimulus(1'b0, 1'b0, 0);
    prime_pc = '0;

    // Randomised traffic: sparse resets and Start pulses, random branch
    // outcomes, occasional spurious BranchTaken, and random fetch jumps.
    $display("[TB] random traffic");
    rand_jumps = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(199) == 0);
      s = ($urandom_range(29) == 0);
      case ($urandom_range(7))
        0:       m = 3;
        1, 2:    m = 0;
        default: m = 4;
      endcase
      apply_stimulus(r, s, m);
    end

    repeat (2) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
